// File: rtl/hub75_receiver.sv
// HUB-75 panel-bus sink: synchronizes the drive bus, rebuilds each latched row and
// replays it as a column-ordered pixel-pair stream; also meters OE on-time and flags bad traffic.
module hub75_receiver #(
   parameter int width       = 64,
   parameter int sync_stages = 2
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        hub_clk,
   input  logic        hub_lat,
   input  logic        hub_oe,
   input  logic [5:0]  hub_rgb,
   input  logic [4:0]  hub_abcde,
   input  logic        clear_errors,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [5:0]  out_x,
   output logic [4:0]  out_y,
   output logic [2:0]  out_rgb1,
   output logic [2:0]  out_rgb2,
   output logic        out_last,
   output logic [15:0] oe_cycles,
   output logic        oe_cycles_valid,
   output logic        overrun,
   output logic        short_row,
   output logic        dbg_state
);

   localparam int         idx_w    = (width > 1) ? $clog2(width) : 1;
   localparam logic [6:0] width_c  = 7'(width);
   localparam logic [5:0] last_idx = 6'(width - 1);

   typedef enum logic {kIdle, kStream} state_t;

   state_t      state_q, state_d;
   logic [5:0]  idx_q, idx_d;
   logic        accept_latch;

   logic [13:0] sync_q [sync_stages];
   logic [13:0] bus_in, bus_s;
   logic        clk_d, lat_d;
   logic        s_clk, s_lat, s_oe;
   logic [5:0]  s_rgb;
   logic [4:0]  s_abcde;
   logic        clk_rise, lat_rise;

   logic [5:0]  shift_reg  [width];
   logic [5:0]  shift_next [width];
   logic [5:0]  hold_buf   [width];
   logic [6:0]  shift_count, count_next;
   logic [15:0] oe_counter;

   // Every HUB-75 line rides the same chain so the bus stays mutually aligned.
   assign bus_in  = {hub_clk, hub_lat, hub_oe, hub_rgb, hub_abcde};
   assign bus_s   = sync_q[sync_stages-1];
   assign s_clk   = bus_s[13];
   assign s_lat   = bus_s[12];
   assign s_oe    = bus_s[11];
   assign s_rgb   = bus_s[10:5];
   assign s_abcde = bus_s[4:0];

   assign clk_rise = s_clk & ~clk_d;
   assign lat_rise = s_lat & ~lat_d;

   always_ff @(posedge clock) begin
      if (!reset) begin
         for (int i = 0; i < sync_stages; i++) sync_q[i] <= '0;
         clk_d <= 1'b0;
         lat_d <= 1'b0;
      end else begin
         sync_q[0] <= bus_in;
         for (int i = 1; i < sync_stages; i++) sync_q[i] <= sync_q[i-1];
         clk_d <= s_clk;
         lat_d <= s_lat;
      end
   end

   // Post-shift view: a latch landing with a shift captures the freshly shifted row.
   always_comb begin
      for (int i = 0; i < width; i++) shift_next[i] = shift_reg[i];
      count_next = shift_count;
      if (clk_rise) begin
         for (int i = 0; i < width - 1; i++) shift_next[i] = shift_reg[i+1];
         shift_next[width-1] = s_rgb;
         if (shift_count != width_c) count_next = shift_count + 7'd1;
      end
   end

   // Stream handshake: a beat transfers on every edge where out_valid && out_ready;
   // while out_valid is high and out_ready low, out_x/out_y/out_rgb*/out_last hold.
   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      accept_latch = 1'b0;
      case (state_q)
         kIdle: begin
            if (lat_rise) begin
               accept_latch = 1'b1;
               state_d      = kStream;
            end
         end
         kStream: begin
            if (out_ready) begin
               if (idx_q == last_idx) begin
                  idx_d   = '0;
                  state_d = kIdle;
               end else begin
                  idx_d = idx_q + 6'd1;
               end
            end
         end
         default: state_d = kIdle;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q <= kIdle;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         for (int i = 0; i < width; i++) begin
            shift_reg[i] <= '0;
            hold_buf[i]  <= '0;
         end
         shift_count     <= '0;
         out_y           <= '0;
         oe_counter      <= '0;
         oe_cycles       <= '0;
         oe_cycles_valid <= 1'b0;
         overrun         <= 1'b0;
         short_row       <= 1'b0;
      end else begin
         shift_reg   <= shift_next;
         shift_count <= lat_rise ? 7'd0 : count_next;
         if (accept_latch) begin
            hold_buf <= shift_next;
            out_y    <= s_abcde;
         end
         // Dropped latches still close the OE measurement interval.
         if (lat_rise) begin
            oe_cycles  <= oe_counter;
            oe_counter <= '0;
         end else if (!s_oe && oe_counter != 16'hFFFF) begin
            oe_counter <= oe_counter + 16'd1;
         end
         oe_cycles_valid <= lat_rise;
         overrun   <= (lat_rise && state_q == kStream) || (overrun && !clear_errors);
         short_row <= (accept_latch && count_next < width_c) || (short_row && !clear_errors);
      end
   end

   assign out_valid = (state_q == kStream);
   assign out_x     = idx_q;
   assign out_last  = out_valid && (idx_q == last_idx);
   assign out_rgb1  = hold_buf[idx_q[idx_w-1:0]][2:0];
   assign out_rgb2  = hold_buf[idx_q[idx_w-1:0]][5:3];
   assign dbg_state = state_q;

endmodule

// File: tb/tb_hub75_receiver.sv
// Bench for hub75_receiver: a row/queue-level model predicts every emitted beat and OE
// measurement; one negedge process compares the DUT against it and drives out_ready.
module tb_hub75_receiver;

   localparam int WIDTH = 64;
   localparam int SYNC  = 2;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        hub_clk = 1'b0, hub_lat = 1'b0, hub_oe = 1'b1;
   logic [5:0]  hub_rgb = '0;
   logic [4:0]  hub_abcde = '0;
   logic        clear_errors = 1'b0;
   logic        out_ready = 1'b0;
   logic        out_valid, out_last, oe_cycles_valid, overrun, short_row, dbg_state;
   logic [5:0]  out_x;
   logic [4:0]  out_y;
   logic [2:0]  out_rgb1, out_rgb2;
   logic [15:0] oe_cycles;

   always #5 clock = ~clock;

   hub75_receiver #(.width(WIDTH), .sync_stages(SYNC)) dut (
      .clock(clock), .reset(reset), .hub_clk(hub_clk), .hub_lat(hub_lat), .hub_oe(hub_oe),
      .hub_rgb(hub_rgb), .hub_abcde(hub_abcde), .clear_errors(clear_errors),
      .out_valid(out_valid), .out_ready(out_ready), .out_x(out_x), .out_y(out_y),
      .out_rgb1(out_rgb1), .out_rgb2(out_rgb2), .out_last(out_last),
      .oe_cycles(oe_cycles), .oe_cycles_valid(oe_cycles_valid),
      .overrun(overrun), .short_row(short_row), .dbg_state(dbg_state)
   );

   int checks = 0;
   int failures = 0;

   // Model: expected beats {last, y, rgb6, x}, expected OE reports, panel row contents.
   logic [17:0] exp_q[$];
   logic [15:0] oe_exp_q[$];
   logic [5:0]  m_sr[$];
   int          m_cnt = 0;
   logic        m_overrun = 1'b0, m_short = 1'b0;
   logic [15:0] m_oe_cnt = '0;
   logic        m_prev_lat = 1'b0;
   int          hs_count = 0;
   int          ready_mode = 0;
   logic [15:0] last_oe = '0;
   logic [5:0]  snap37 = '0;
   logic        snap_last = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // OE model on raw samples; the synchronizer zeros after reset read as OE active.
   always @(posedge clock) begin
      if (!reset) begin
         m_oe_cnt   = 16'(SYNC);
         m_prev_lat = 1'b0;
         oe_exp_q.delete();
      end else begin
         if (hub_lat && !m_prev_lat) begin
            oe_exp_q.push_back(m_oe_cnt);
            m_oe_cnt = '0;
         end else if (!hub_oe && m_oe_cnt != 16'hFFFF) begin
            m_oe_cnt = m_oe_cnt + 16'd1;
         end
         m_prev_lat = hub_lat;
      end
   end

   always @(negedge clock) begin
      logic rdy;
      if (reset) begin
         if (out_valid) begin
            if (exp_q.size() == 0) check("unexpected_beat", 1, 0);
            else check("beat", {out_last, out_y, out_rgb2, out_rgb1, out_x}, exp_q[0]);
            if (out_x == 6'd37) snap37 = {out_rgb2, out_rgb1};
            if (out_x == 6'd63) snap_last = out_last;
         end
         if (oe_cycles_valid) begin
            if (oe_exp_q.size() == 0) check("unexpected_oe_strobe", 1, 0);
            else check("oe_cycles", oe_cycles, oe_exp_q.pop_front());
            last_oe = oe_cycles;
         end
         case (ready_mode)
            0:       rdy = 1'b1;
            1:       rdy = ($urandom_range(0, 2) != 0);
            default: rdy = 1'b0;
         endcase
         if (out_valid && rdy && exp_q.size() != 0) begin
            void'(exp_q.pop_front());
            hs_count++;
         end
         out_ready = rdy;
      end
   end

   task automatic shift_pixel(input logic [5:0] rgb);
      hub_rgb = rgb;
      repeat (2) @(negedge clock);
      hub_clk = 1'b1;
      void'(m_sr.pop_front());
      m_sr.push_back(rgb);
      if (m_cnt < WIDTH) m_cnt++;
      repeat (2) @(negedge clock);
      hub_clk = 1'b0;
   endtask

   task automatic shift_random(input int n);
      for (int i = 0; i < n; i++) shift_pixel(6'($urandom_range(0, 63)));
   endtask

   task automatic latch_row(input logic [4:0] y);
      hub_abcde = y;
      hub_lat   = 1'b1;
      if (exp_q.size() != 0) begin
         m_overrun = 1'b1;
      end else begin
         if (m_cnt < WIDTH) m_short = 1'b1;
         for (int i = 0; i < WIDTH; i++) exp_q.push_back({(i == WIDTH-1), y, m_sr[i], 6'(i)});
      end
      m_cnt = 0;
      repeat (2) @(negedge clock);
      hub_lat = 1'b0;
      repeat (2) @(negedge clock);
   endtask

   task automatic drain(input string name);
      int n = 0;
      while ((exp_q.size() != 0 || out_valid) && n < 4000) begin
         @(negedge clock);
         n++;
      end
      check({name, "_drain_timeout"}, 32'(n < 4000), 1);
      repeat (4) @(negedge clock);
   endtask

   task automatic check_flags(input string name);
      check({name, "_overrun"}, overrun, m_overrun);
      check({name, "_short_row"}, short_row, m_short);
   endtask

   task automatic pulse_clear();
      @(negedge clock);
      clear_errors = 1'b1;
      m_overrun = 1'b0;
      m_short   = 1'b0;
      @(negedge clock);
      clear_errors = 1'b0;
      check_flags("clear");
   endtask

   task automatic do_reset();
      @(posedge clock);
      #2 reset = 1'b0;
      exp_q.delete();
      m_sr.delete();
      for (int i = 0; i < WIDTH; i++) m_sr.push_back(6'd0);
      m_cnt = 0;
      m_overrun = 1'b0;
      m_short = 1'b0;
      hs_count = 0;
      @(posedge clock);
      #2;
      check("rst_out_valid", out_valid, 0);
      check("rst_out_last", out_last, 0);
      check("rst_out_x", out_x, 0);
      check("rst_out_y", out_y, 0);
      check("rst_out_rgb", {out_rgb2, out_rgb1}, 0);
      check("rst_oe_cycles", oe_cycles, 0);
      check("rst_oe_valid", oe_cycles_valid, 0);
      check("rst_flags", {overrun, short_row}, 0);
      @(posedge clock);
      #2 reset = 1'b1;
      @(negedge clock);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog expired actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      do_reset();

      // Full row with rgb = column index.
      ready_mode = 0;
      for (int x = 0; x < WIDTH; x++) shift_pixel(6'(x));
      hs_count = 0;
      latch_row(5'd5);
      drain("row_a");
      check("row_a_beats", hs_count, 64);
      check("row_a_pix37", snap37, 6'd37);
      check("row_a_last63", snap_last, 1);
      check("row_a_short_row", short_row, 0);
      check_flags("row_a");

      // Short row still streams a full width.
      shift_random(40);
      hs_count = 0;
      latch_row(5'($urandom_range(0, 31)));
      check("row_b_short_row", short_row, 1);
      drain("row_b");
      check("row_b_beats", hs_count, 64);
      check_flags("row_b");
      pulse_clear();
      check("row_b_cleared", short_row, 0);

      // Second latch during a stalled stream is dropped.
      shift_random(WIDTH);
      ready_mode = 2;
      hs_count = 0;
      latch_row(5'd3);
      shift_random(1);
      repeat (2) @(negedge clock);
      latch_row(5'd9);
      repeat (4) @(negedge clock);
      check("ovr_overrun", overrun, 1);
      check_flags("ovr");
      ready_mode = 1;
      drain("ovr");
      check("ovr_beats", hs_count, 64);
      pulse_clear();

      // Random backpressure.
      shift_random(WIDTH);
      hs_count = 0;
      latch_row(5'($urandom_range(0, 31)));
      drain("bp");
      check("bp_beats", hs_count, 64);
      check_flags("bp");

      // OE meter: 300 cycles, then saturation.
      ready_mode = 0;
      hub_oe = 1'b0;
      repeat (300) @(negedge clock);
      hub_oe = 1'b1;
      latch_row(5'd1);
      drain("oe300");
      check("oe300_value", last_oe, 16'd300);
      pulse_clear();
      hub_oe = 1'b0;
      repeat (70000) @(negedge clock);
      hub_oe = 1'b1;
      latch_row(5'd2);
      drain("oe_sat");
      check("oe_sat_value", last_oe, 16'hFFFF);
      pulse_clear();

      // Reset mid-stream, then a fresh row.
      shift_random(WIDTH);
      hs_count = 0;
      latch_row(5'd7);
      for (int n = 0; n < 500 && exp_q.size() > 44; n++) @(negedge clock);
      check("mid_reset_reached_beat20", 32'(exp_q.size() <= 44), 1);
      do_reset();
      shift_random(WIDTH);
      ready_mode = 1;
      latch_row(5'd12);
      drain("post_reset");
      check("post_reset_beats", hs_count, 64);
      check_flags("post_reset");

      check("exp_q_empty", exp_q.size(), 0);
      check("oe_q_empty", oe_exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
